// File: rtl/car_pass_gen.sv
// Two-beam car-park gate emulator: turns queued entry/exit commands into a/b beam waveforms.
// Optional macro CAR_BALK_EN: a latched req_balk=1 ends the pass after LEAD (car backs out, not counted).
module car_pass_gen #(
    parameter int DWELL_W = 8,
    parameter int GAP_CYC = 2,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_dir,
    input  logic               req_balk,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   enter_cnt,
    output logic [CNT_W-1:0]   exit_cnt
);
    localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int DW_MAX  = (1 << DWELL_W) - 1;
    localparam int PH_MAX  = (DW_MAX > GAP_EFF) ? DW_MAX : GAP_EFF;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_GAP  = PH_W'(GAP_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, LEAD, BOTH, TRAIL, GAP} state_t;

    state_t            state_q;
    logic [PH_W-1:0]   ph_q;
    logic [PH_W-1:0]   dwell_q;
    logic [PH_W-1:0]   dwell_d;
    logic              dir_q;
    logic              balk_q;
    logic              balk_d;
    logic              a_q, b_q, busy_q, done_q;
    logic [CNT_W-1:0]  enter_q, exit_q;

    assign dwell_d = (dwell == '0) ? PH_ONE : PH_W'(dwell);

`ifdef CAR_BALK_EN
    assign balk_d = req_balk;
`else
    logic unused_balk;
    assign balk_d      = 1'b0;
    assign unused_balk = req_balk;
`endif

    assign req_ready = (state_q == IDLE);
    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign enter_cnt = enter_q;
    assign exit_cnt  = exit_q;

    // Beam outputs are set on the edge that enters each state; lead beam is a for entry, b for exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_q    <= '0;
            dwell_q <= '0;
            dir_q   <= 1'b0;
            balk_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enter_q <= '0;
            exit_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= LEAD;
                        dir_q   <= req_dir;
                        balk_q  <= balk_d;
                        dwell_q <= dwell_d;
                        ph_q    <= dwell_d;
                        a_q     <= ~req_dir;
                        b_q     <= req_dir;
                        busy_q  <= 1'b1;
                    end
                end
                LEAD: begin
                    if (ph_q == PH_ONE) begin
                        if (balk_q) begin
                            state_q <= GAP;
                            ph_q    <= PH_GAP;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                        end else begin
                            state_q <= BOTH;
                            ph_q    <= dwell_q;
                            a_q     <= 1'b1;
                            b_q     <= 1'b1;
                        end
                    end else begin
                        ph_q <= ph_q - PH_ONE;
                    end
                end
                BOTH: begin
                    if (ph_q == PH_ONE) begin
                        state_q <= TRAIL;
                        ph_q    <= dwell_q;
                        a_q     <= dir_q;
                        b_q     <= ~dir_q;
                    end else begin
                        ph_q <= ph_q - PH_ONE;
                    end
                end
                TRAIL: begin
                    if (ph_q == PH_ONE) begin
                        state_q <= GAP;
                        ph_q    <= PH_GAP;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                    end else begin
                        ph_q <= ph_q - PH_ONE;
                    end
                end
                GAP: begin
                    if (ph_q == PH_ONE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!balk_q) begin
                            if (dir_q) exit_q  <= exit_q + CNT_ONE;
                            else       enter_q <= enter_q + CNT_ONE;
                        end
                    end else begin
                        ph_q <= ph_q - PH_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_car_pass_gen.sv
// Directed + randomized bench for car_pass_gen against a waveform-list reference model.
module tb_car_pass_gen;
  localparam int DWELL_W = 8;
  localparam int GAP     = 2;
  localparam int CNT_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic               req_dir;
  logic               req_balk;
  logic [DWELL_W-1:0] dwell;
  logic               a;
  logic               b;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   enter_cnt;
  logic [CNT_W-1:0]   exit_cnt;

  int total = 0;
  int bad   = 0;
  int m_enter = 0;
  int m_exit  = 0;

  car_pass_gen #(.DWELL_W(DWELL_W), .GAP_CYC(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_balk(req_balk), .dwell(dwell),
    .a(a), .b(b), .busy(busy), .done(done),
    .enter_cnt(enter_cnt), .exit_cnt(exit_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({a, b, busy, done, req_ready});
  endfunction

  function automatic logic [31:0] cnts();
    return 32'({enter_cnt, exit_cnt});
  endfunction

  function automatic logic [31:0] model_cnts();
    return 32'({4'(m_enter), 4'(m_exit)});
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_pass(input logic dir, input int dw, input logic balk, input bit hold,
                          input string tag);
    logic [1:0] exp_q[$];
    logic [1:0] lead, trail, ab;
    logic       eff_balk;
    int         d;
    d = (dw == 0) ? 1 : dw;
`ifdef CAR_BALK_EN
    eff_balk = balk;
`else
    eff_balk = 1'b0;
`endif
    lead  = dir ? 2'b01 : 2'b10;
    trail = dir ? 2'b10 : 2'b01;
    repeat (d) exp_q.push_back(lead);
    if (!eff_balk) begin
      repeat (d) exp_q.push_back(2'b11);
      repeat (d) exp_q.push_back(trail);
    end
    repeat (GAP) exp_q.push_back(2'b00);

    req_valid = 1'b1;
    req_dir   = dir;
    req_balk  = balk;
    dwell     = DWELL_W'(dw);
    chk($sformatf("%s:ready_at_req", tag), 32'(req_ready), 32'(1));
    @(posedge clk);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = hold;
        req_dir   = 1'($urandom);
        req_balk  = 1'($urandom);
        dwell     = DWELL_W'($urandom);
      end
      ab = exp_q.pop_front();
      chk($sformatf("%s:cyc%0d", tag, k), outs(), 32'({ab, 3'b100}));
    end
    @(negedge clk);
    if (!eff_balk) begin
      if (dir) m_exit++;
      else     m_enter++;
    end
    chk($sformatf("%s:done_cycle", tag), outs(), 32'(5'b00011));
    chk($sformatf("%s:counts", tag), cnts(), model_cnts());
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_dir   = 1'b0;
    req_balk  = 1'b0;
    dwell     = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'(5'b00001));
    chk("reset_cnts", cnts(), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(1'b0, 2, 1'b0, 1'b0, "entry_d2");
    chk("entry_d2_enter1", cnts(), 32'({4'd1, 4'd0}));
    run_pass(1'b1, 3, 1'b0, 1'b0, "exit_d3");
    chk("exit_d3_exit1", cnts(), 32'({4'd1, 4'd1}));
    run_pass(1'b0, 0, 1'b0, 1'b0, "entry_d0");
    run_pass(1'b1, 0, 1'b0, 1'b0, "exit_d0");

    // back-to-back with req_valid held
    run_pass(1'b0, 1, 1'b0, 1'b1, "b2b_0");
    run_pass(1'b1, 2, 1'b0, 1'b1, "b2b_1");
    run_pass(1'b0, 1, 1'b0, 1'b0, "b2b_2");
    chk("b2b_counts", cnts(), 32'({4'd4, 4'd3}));

    // balk request: honoured only with CAR_BALK_EN
    run_pass(1'b0, 3, 1'b1, 1'b0, "balk_entry");
    run_pass(1'b1, 2, 1'b1, 1'b0, "balk_exit");

    // asynchronous reset during BOTH
    req_valid = 1'b1;
    req_dir   = 1'b0;
    req_balk  = 1'b0;
    dwell     = DWELL_W'(4);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_both", outs(), 32'(5'b11100));
    #2;
    rst_n = 1'b0;
    #1;
    m_enter = 0;
    m_exit  = 0;
    chk("rst_async_outs", outs(), 32'(5'b00001));
    chk("rst_async_cnts", cnts(), 32'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_outs", outs(), 32'(5'b00001));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", outs(), 32'(5'b00001));
    run_pass(1'b0, 2, 1'b0, 1'b0, "post_reset");

    // 15 more entries -> 16 since reset, counter wraps to 0
    for (int i = 0; i < 15; i++)
      run_pass(1'b0, $urandom_range(0, 2), 1'b0, 1'($urandom), $sformatf("wrap%0d", i));
    req_valid = 1'b0;
    chk("wrap_enter_zero", 32'(enter_cnt), 32'(0));
    chk("wrap_exit_zero", 32'(exit_cnt), 32'(0));

    // randomized commands
    for (int i = 0; i < 12; i++)
      run_pass(1'($urandom), $urandom_range(0, 5), 1'($urandom), 1'($urandom),
               $sformatf("rand%0d", i));
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_tail", outs(), 32'(5'b00001));
    end
    chk("final_counts", cnts(), model_cnts());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
